// File: rtl/cnn1d_pkg.sv
// -----------------------------------------------------------------------------
// cnn1d_pkg
// Shared types for the 1-D convolution datapath.
//   DATA_WIDTH      default sample/weight/bias width (two's complement)
//   data_t          signed sample type
//   feeder_state_t  window feeder FSM states
//   pad_count()     'same' padding depth for a kernel of k taps
// -----------------------------------------------------------------------------
package cnn1d_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } feeder_state_t;

    function automatic int pad_count(input int k);
        return (k - 1) / 2;
    endfunction

endpackage

// File: rtl/cnn1d_shift_window.sv
// -----------------------------------------------------------------------------
// cnn1d_shift_window
// K-deep sample shift register holding the current convolution window.
//   clk, rst   clock, async active-high reset (window cleared)
//   shift_en   shift one sample in: win[i] <= win[i+1], win[K-1] <= din
//   clear      zero the window; combined with shift_en the old contents are
//              zeroed first, so the window becomes {0, .., 0, din}
//   din        incoming sample
//   window     window contents, window[0] oldest, window[K-1] newest
// Zero-preloading for padded sequences falls out of clear: after a clear the
// older taps are zeros until enough real samples have been shifted in.
// -----------------------------------------------------------------------------
module cnn1d_shift_window #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  shift_en,
    input  logic                                  clear,
    input  logic [DATA_WIDTH-1:0]                 din,
    output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window
);

    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_q;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_d;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] base;

    always_comb begin
        base  = clear ? '0 : win_q;
        win_d = base;
        if (shift_en) begin
            for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
                win_d[i] = base[i+1];
            end
            win_d[KERNEL_SIZE-1] = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign window = win_q;

endmodule

// File: rtl/conv1d_window_feeder.sv
// -----------------------------------------------------------------------------
// conv1d_window_feeder
// Builds a KERNEL_SIZE sliding window from a scalar valid/ready sample stream
// and presents it, together with the weight bank and bias, to a neuron over a
// valid/ready handshake.
//   clk, rst                 clock, async active-high reset
//   s_data/s_valid/s_ready   input sample stream, s_last marks final sample
//   w_wr_en/addr/data        weight write port; b_wr_en writes bias from
//                            w_wr_data. Writes are dropped while m_valid is set
//   a                        window, a[0] oldest, a[K-1] newest
//   w, bias                  weight bank and bias register, direct
//   m_valid/m_ready/m_last   window handshake, m_last on final window
// Optional feature: define CNN1D_ZERO_PAD_EN for 'same' padding with
// P = (K-1)/2 zeros at each end of a sequence (adds the FLUSH state).
//
// state | meaning
// FILL  | collecting samples until the window is first full
// RUN   | window full, emitting every STRIDE accepted samples
// FLUSH | (padding only) injecting trailing zero samples, input stalled
// -----------------------------------------------------------------------------
module conv1d_window_feeder
    import cnn1d_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int DATA_WIDTH  = cnn1d_pkg::DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic                                   s_last,
    input  logic                                   w_wr_en,
    input  logic [$clog2(KERNEL_SIZE)-1:0]         w_wr_addr,
    input  logic [DATA_WIDTH-1:0]                  w_wr_data,
    input  logic                                   b_wr_en,
    output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] a,
    output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] w,
    output logic [DATA_WIDTH-1:0]                  bias,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   m_last
);

    localparam int AW = $clog2(KERNEL_SIZE);
    localparam int FW = $clog2(KERNEL_SIZE + 1);
    localparam int SW = $clog2(STRIDE + 1);
`ifdef CNN1D_ZERO_PAD_EN
    localparam int PAD = pad_count(KERNEL_SIZE);
    localparam int PW  = $clog2(PAD + 2);
    localparam logic [PW-1:0] PAD_LAST = PW'((PAD > 0) ? PAD - 1 : 0);
`else
    localparam int PAD = 0;
`endif
    localparam bit FLUSH_EN = (PAD > 0);

    // fill_cnt == FILL_FULL marks "window already full" so FLUSH can tell a
    // completed window from one still being filled by the pads.
    localparam logic [FW-1:0] FILL_START  = FW'(PAD);
    localparam logic [FW-1:0] FILL_LAST   = FW'(KERNEL_SIZE - 1);
    localparam logic [FW-1:0] FILL_FULL   = FW'(KERNEL_SIZE);
    localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);
    localparam logic [AW:0]   ADDR_LIMIT  = (AW+1)'(KERNEL_SIZE);

    feeder_state_t state_q, state_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic [SW-1:0] stride_cnt_q, stride_cnt_d;
    logic          fresh_q, fresh_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] w_q, w_d;
    logic [DATA_WIDTH-1:0] bias_q, bias_d;
`ifdef CNN1D_ZERO_PAD_EN
    logic [PW-1:0] pad_cnt_q, pad_cnt_d;
`endif

    logic                  slot_free;
    logic                  accept;
    logic                  stride_hit;
    logic                  shift_en;
    logic                  win_clear;
    logic [DATA_WIDTH-1:0] shift_din;
    logic                  emit;
    logic                  emit_last;
    logic                  restart;

    // The output slot frees when empty or being consumed this cycle.
    assign slot_free = !m_valid_q || m_ready;
    assign s_ready   = slot_free && (state_q != FLUSH);
    assign accept    = s_valid && s_ready;

    cnn1d_shift_window #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (win_clear),
        .din      (shift_din),
        .window   (a)
    );

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        stride_cnt_d = stride_cnt_q;
        fresh_d      = fresh_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        w_d          = w_q;
        bias_d       = bias_q;
        shift_en     = 1'b0;
        win_clear    = 1'b0;
        shift_din    = s_data;
        emit         = 1'b0;
        emit_last    = 1'b0;
        restart      = 1'b0;
        stride_hit   = (stride_cnt_q == STRIDE_LAST);
`ifdef CNN1D_ZERO_PAD_EN
        pad_cnt_d    = pad_cnt_q;
`endif

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    shift_en = 1'b1;
                    // Old window is only discarded on the first sample of the
                    // next sequence, so a still-pending window stays intact.
                    win_clear = fresh_q;
                    fresh_d   = 1'b0;
                    if (fill_cnt_q == FILL_LAST) begin
                        emit         = 1'b1;
                        stride_cnt_d = '0;
                        fill_cnt_d   = FILL_FULL;
                        if (!s_last) begin
                            state_d = RUN;
                        end else if (FLUSH_EN) begin
                            state_d = FLUSH;
                        end else begin
                            emit_last = 1'b1;
                            restart   = 1'b1;
                        end
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        if (s_last) begin
                            if (FLUSH_EN) begin
                                state_d = FLUSH;
                            end else begin
                                restart = 1'b1;
                            end
                        end
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    shift_en     = 1'b1;
                    stride_cnt_d = stride_hit ? '0 : stride_cnt_q + 1'b1;
                    if (s_last && !FLUSH_EN) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        restart   = 1'b1;
                    end else begin
                        emit = stride_hit;
                        if (s_last) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
`ifdef CNN1D_ZERO_PAD_EN
            FLUSH: begin
                if (slot_free) begin
                    shift_en  = 1'b1;
                    shift_din = '0;
                    pad_cnt_d = pad_cnt_q + 1'b1;
                    if (fill_cnt_q == FILL_FULL) begin
                        emit         = stride_hit;
                        stride_cnt_d = stride_hit ? '0 : stride_cnt_q + 1'b1;
                    end else if (fill_cnt_q == FILL_LAST) begin
                        emit         = 1'b1;
                        stride_cnt_d = '0;
                        fill_cnt_d   = FILL_FULL;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                    // Final pad closes the sequence; emit only if full.
                    if (pad_cnt_q == PAD_LAST) begin
                        emit      = (fill_cnt_q >= FILL_LAST);
                        emit_last = (fill_cnt_q >= FILL_LAST);
                        pad_cnt_d = '0;
                        restart   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            state_d      = FILL;
            fill_cnt_d   = FILL_START;
            stride_cnt_d = '0;
            fresh_d      = 1'b1;
        end

        // emit implies slot_free, so a held window is never overwritten.
        if (emit) begin
            m_valid_d = 1'b1;
            m_last_d  = emit_last;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (!m_valid_q) begin
            if (w_wr_en && ({1'b0, w_wr_addr} < ADDR_LIMIT)) begin
                w_d[w_wr_addr] = w_wr_data;
            end
            if (b_wr_en) begin
                bias_d = w_wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            fill_cnt_q   <= FILL_START;
            stride_cnt_q <= '0;
            fresh_q      <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            w_q          <= '0;
            bias_q       <= '0;
`ifdef CNN1D_ZERO_PAD_EN
            pad_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            fresh_q      <= fresh_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            w_q          <= w_d;
            bias_q       <= bias_d;
`ifdef CNN1D_ZERO_PAD_EN
            pad_cnt_q    <= pad_cnt_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign w       = w_q;
    assign bias    = bias_q;

endmodule

// File: tb/tb_conv1d_window_feeder.sv
`timescale 1ns/1ps
module tb_conv1d_window_feeder;
    import cnn1d_pkg::*;

    localparam int K  = 3;
    localparam int DW = DATA_WIDTH;

    typedef struct packed {
        logic [K*DW-1:0] win;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] s_data [2];
    logic s_valid [2];
    logic s_last  [2];
    logic m_ready [2];
    logic s_ready [2];
    logic [K-1:0][DW-1:0] a_o [2];
    logic [K-1:0][DW-1:0] w_o [2];
    logic [DW-1:0] bias_o [2];
    logic m_valid [2];
    logic m_last  [2];
    logic w_wr_en;
    logic [1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;
    logic b_wr_en;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv1d_window_feeder #(.KERNEL_SIZE(K), .STRIDE(1), .DATA_WIDTH(DW)) u_s1 (
        .clk(clk), .rst(rst),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_last(s_last[0]),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .b_wr_en(b_wr_en),
        .a(a_o[0]), .w(w_o[0]), .bias(bias_o[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0])
    );

    conv1d_window_feeder #(.KERNEL_SIZE(K), .STRIDE(2), .DATA_WIDTH(DW)) u_s2 (
        .clk(clk), .rst(rst),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_last(s_last[1]),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .b_wr_en(b_wr_en),
        .a(a_o[1]), .w(w_o[1]), .bias(bias_o[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1])
    );

    function automatic logic [K*DW-1:0] win3(input int x0, input int x1, input int x2);
        return {DW'(x2), DW'(x1), DW'(x0)};
    endfunction

    function automatic int qsize(input int inst);
        return (inst == 0) ? q0.size() : q1.size();
    endfunction

    task automatic expect_win(input int inst, input int x0, input int x1, input int x2,
                              input logic last);
        exp_t e;
        e.win  = win3(x0, x1, x2);
        e.last = last;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    // Scoreboard: every consumed window is checked against the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i] === 1'b1 && m_ready[i] === 1'b1) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                e    = '0;
                if (i == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (i == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                total++;
                if (!have) begin
                    bad++;
                    $display("FAIL unexpected_window inst=%0d got a=%h last=%b, none expected",
                             i, a_o[i], m_last[i]);
                end else if (a_o[i] !== e.win || m_last[i] !== e.last) begin
                    bad++;
                    $display("FAIL window inst=%0d got a=%h last=%b want a=%h last=%b",
                             i, a_o[i], m_last[i], e.win, e.last);
                end
            end
        end
    end

    task automatic send(input int inst, input int data, input logic last);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        s_data[inst]  = DW'(data);
        s_last[inst]  = last;
        s_valid[inst] = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_ready[inst];
            @(posedge clk);
            #1;
            n++;
        end
        s_valid[inst] = 1'b0;
        s_last[inst]  = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_accept inst=%0d data=%0d got s_ready=0 want 1", inst, data);
        end
    endtask

    task automatic wait_drain(input int inst);
        int n;
        n = 0;
        while ((qsize(inst) != 0 || m_valid[inst] !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL drain inst=%0d got pending=%0d m_valid=%b want 0/0",
                     inst, qsize(inst), m_valid[inst]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input int addr, input int data);
        w_wr_addr = 2'(addr);
        w_wr_data = DW'(data);
        w_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        w_wr_en   = 1'b0;
    endtask

    task automatic wr_b(input int data);
        w_wr_data = DW'(data);
        b_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        b_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total += 5;
            if (m_valid[i] !== 1'b0) begin bad++; $display("FAIL rst_m_valid inst=%0d got %b want 0", i, m_valid[i]); end
            if (m_last[i] !== 1'b0)  begin bad++; $display("FAIL rst_m_last inst=%0d got %b want 0", i, m_last[i]); end
            if (a_o[i] !== '0)       begin bad++; $display("FAIL rst_a inst=%0d got %h want 0", i, a_o[i]); end
            if (w_o[i] !== '0)       begin bad++; $display("FAIL rst_w inst=%0d got %h want 0", i, w_o[i]); end
            if (bias_o[i] !== '0)    begin bad++; $display("FAIL rst_bias inst=%0d got %h want 0", i, bias_o[i]); end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (s_ready[i] !== 1'b1) begin bad++; $display("FAIL rst_s_ready inst=%0d got %b want 1", i, s_ready[i]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        wr_w(0, 1);
        wr_w(1, 2);
        wr_w(2, 3);
        wr_b(5);
        @(negedge clk);
        total += 2;
        if (w_o[0] !== win3(1, 2, 3)) begin bad++; $display("FAIL basic_w got %h want %h", w_o[0], win3(1, 2, 3)); end
        if (bias_o[0] !== DW'(5))     begin bad++; $display("FAIL basic_bias got %h want 05", bias_o[0]); end
        @(posedge clk);
        #1;
        expect_win(0, 1, 2, 3, 1'b0);
        expect_win(0, 2, 3, 4, 1'b0);
        expect_win(0, 3, 4, -5, 1'b1);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 3, 1'b0);
        send(0, 4, 1'b0);
        send(0, -5, 1'b1);
        wait_drain(0);
    endtask

    task automatic test_backpressure();
        expect_win(0, 1, 2, 3, 1'b0);
        expect_win(0, 2, 3, 4, 1'b0);
        expect_win(0, 3, 4, -5, 1'b1);
        fork
            begin
                send(0, 1, 1'b0);
                send(0, 2, 1'b0);
                send(0, 3, 1'b0);
                send(0, 4, 1'b0);
                send(0, -5, 1'b1);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!(m_valid[0] === 1'b1 && a_o[0] === win3(1, 2, 3)) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) begin
                    total++;
                    bad++;
                    $display("FAIL bp_first_window got a=%h want %h", a_o[0], win3(1, 2, 3));
                end
                @(posedge clk);
                #1;
                m_ready[0] = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    total += 3;
                    if (m_valid[0] !== 1'b1)        begin bad++; $display("FAIL bp_hold_valid got %b want 1", m_valid[0]); end
                    if (a_o[0] !== win3(2, 3, 4))  begin bad++; $display("FAIL bp_hold_a got %h want %h", a_o[0], win3(2, 3, 4)); end
                    if (s_ready[0] !== 1'b0)       begin bad++; $display("FAIL bp_s_ready got %b want 0", s_ready[0]); end
                end
                @(posedge clk);
                #1;
                m_ready[0] = 1'b1;
            end
        join
        wait_drain(0);
    endtask

    task automatic test_stride();
        expect_win(1, 1, 2, 3, 1'b0);
        expect_win(1, 3, 4, 5, 1'b0);
        expect_win(1, 5, 6, 7, 1'b1);
        for (int v = 1; v <= 7; v++) send(1, v, (v == 7));
        wait_drain(1);
        expect_win(1, 1, 2, 3, 1'b0);
        expect_win(1, 3, 4, 5, 1'b0);
        expect_win(1, 4, 5, 6, 1'b1);
        for (int v = 1; v <= 6; v++) send(1, v, (v == 6));
        wait_drain(1);
    endtask

    task automatic test_short_last();
        send(0, 8, 1'b0);
        send(0, 9, 1'b1);
        repeat (3) begin
            @(negedge clk);
            total++;
            if (m_valid[0] !== 1'b0) begin bad++; $display("FAIL short_no_window got m_valid=%b want 0", m_valid[0]); end
        end
        @(posedge clk);
        #1;
        expect_win(0, 1, 2, 3, 1'b1);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 3, 1'b1);
        wait_drain(0);
    endtask

    task automatic test_weight_hold();
        m_ready[0] = 1'b0;
        expect_win(0, 1, 2, 3, 1'b0);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 3, 1'b0);
        wr_w(0, 7);
        wr_b(9);
        @(negedge clk);
        total += 3;
        if (m_valid[0] !== 1'b1)      begin bad++; $display("FAIL wh_valid got %b want 1", m_valid[0]); end
        if (w_o[0] !== win3(1, 2, 3)) begin bad++; $display("FAIL wh_w_held got %h want %h", w_o[0], win3(1, 2, 3)); end
        if (bias_o[0] !== DW'(5))     begin bad++; $display("FAIL wh_bias_held got %h want 05", bias_o[0]); end
        @(posedge clk);
        #1;
        m_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        wr_w(0, 7);
        @(negedge clk);
        total++;
        if (w_o[0] !== win3(7, 2, 3)) begin bad++; $display("FAIL wh_w_write got %h want %h", w_o[0], win3(7, 2, 3)); end
        @(posedge clk);
        #1;
        wr_w(3, 9);
        @(negedge clk);
        total++;
        if (w_o[0] !== win3(7, 2, 3)) begin bad++; $display("FAIL wh_w_oob got %h want %h", w_o[0], win3(7, 2, 3)); end
        @(posedge clk);
        #1;
        wait_drain(0);
    endtask

    task automatic test_reset_mid();
        m_ready[0] = 1'b0;
        send(0, 4, 1'b0);
        @(negedge clk);
        total++;
        if (m_valid[0] !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got %b want 1", m_valid[0]); end
        #2;
        rst = 1'b1;
        #1;
        total += 5;
        if (m_valid[0] !== 1'b0) begin bad++; $display("FAIL rm_m_valid got %b want 0", m_valid[0]); end
        if (m_last[0] !== 1'b0)  begin bad++; $display("FAIL rm_m_last got %b want 0", m_last[0]); end
        if (a_o[0] !== '0)       begin bad++; $display("FAIL rm_a got %h want 0", a_o[0]); end
        if (w_o[0] !== '0)       begin bad++; $display("FAIL rm_w got %h want 0", w_o[0]); end
        if (bias_o[0] !== '0)    begin bad++; $display("FAIL rm_bias got %h want 0", bias_o[0]); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready[0] = 1'b1;
        expect_win(0, 1, 2, 3, 1'b0);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 3, 1'b0);
        wait_drain(0);
    endtask

    task automatic test_pad();
        expect_win(0, 0, 1, 2, 1'b0);
        expect_win(0, 1, 2, 3, 1'b0);
        expect_win(0, 2, 3, 4, 1'b0);
        expect_win(0, 3, 4, 0, 1'b1);
        for (int v = 1; v <= 4; v++) send(0, v, (v == 4));
        wait_drain(0);
        expect_win(1, 0, 1, 2, 1'b0);
        expect_win(1, 2, 3, 4, 1'b0);
        expect_win(1, 3, 4, 0, 1'b1);
        for (int v = 1; v <= 4; v++) send(1, v, (v == 4));
        wait_drain(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        w_wr_en = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        b_wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_data[i]  = '0;
            s_valid[i] = 1'b0;
            s_last[i]  = 1'b0;
            m_ready[i] = 1'b1;
        end
        #1;
        test_reset();
`ifdef CNN1D_ZERO_PAD_EN
        test_pad();
`else
        test_basic();
        test_backpressure();
        test_stride();
        test_short_last();
        test_weight_hold();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
